wb_sram_rd_stream: RTL and testbench
====================================

Name: wb_sram_rd_stream

Overview:
- Read-side controller for the weight-buffer simple dual-port SRAM.
- Accepts a (base address, length) read command and drives the SRAM read port (enb/addrb), compensating for its fixed 1-cycle read latency.
- Emits the words as a valid/ready stream with a last flag toward the PE-array weight loader.
- A 2-entry output buffer absorbs backpressure without losing read data; full throughput is 1 word/cycle.

Parameters:
- AW, 13, SRAM address width; depth DP = 2**AW.
- DW, 416, SRAM/stream word width.
- LW, AW+1, command length width; max length = DP words.

Ports:
- clk  input  1  single clock for all logic and the SRAM read port.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  input  AW  first word address.
- cmd_len  input  LW  number of words to read; 0 allowed.
- cmd_stride  input  AW  address increment; present only with WB_RD_STRIDE_EN.
- sram_enb  output  1  SRAM port-B read enable.
- sram_addrb  output  AW  SRAM port-B address.
- sram_doutb  input  DW  SRAM port-B data, valid 1 cycle after sram_enb.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accept.
- out_data  output  DW  stream word.
- out_last  output  1  marks final word of the command.
- busy  output  1  command in progress (not IDLE).
- done  output  1  one-cycle pulse when a command fully completes.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state IDLE, both buffer entries empty, in-flight flag cleared.
  - cmd_ready=1 after reset; sram_enb=0, out_valid=0, out_last=0, busy=0, done=0.
  - out_data and sram_addrb are don't-care.
- Reset mid-command: aborts immediately. Any in-flight SRAM word is discarded, no done pulse, next cycle is IDLE.
- IDLE:
  - cmd_ready=1.
  - On handshake: latch addr (and stride, else 1) and len.
  - len==0: no SRAM access, done=1 the next cycle, remain IDLE.
  - len>0: go to ISSUE.
- ISSUE (cmd_ready=0, busy=1):
  - Issue a read (sram_enb=1, sram_addrb=cur_addr) when remaining>0 and (buf_count + inflight - pop) <= 1, where pop = out_valid & out_ready this cycle.
  - This credit rule guarantees every returning word has a buffer slot and sustains 1 word/cycle under continuous out_ready.
  - Each issue: cur_addr = (cur_addr + stride) mod DP, with silent wrap from DP-1 to 0; remaining decrements.
  - When remaining reaches 0, go to DRAIN.
- Data return: inflight=1 in the cycle after an issue. sram_doutb is captured into the buffer tail in that cycle, tagged last if it was the final issue.
- DRAIN: no further issues. When the last-tagged word pops, done=1 for exactly one cycle (the cycle after the pop), then IDLE with cmd_ready=1.
- Stream rules:
  - out_data/out_last are the buffer head, registered.
  - Head is held stable while out_valid & !out_ready.
  - Order equals issue order.
  - out_last=1 only together with out_valid on the final word.
  - Push and pop in the same cycle are both honoured.
- Latency: first out_valid occurs 2 cycles after the command handshake (issue cycle +1, capture +1).
- A new command is not accepted until done for the previous one has fired.

Optional Feature:
- Macro: WB_RD_STRIDE_EN.
- Defined: the cmd_stride port exists and is latched at the handshake. stride=0 legally re-reads the same address len times. Wrap is mod DP.
- Undefined: no cmd_stride port; the increment is a constant 1.

Test Plan:
- Contiguous read: cmd_addr=0x10, cmd_len=4, out_ready=1, SRAM preloaded data[a]=a.
  - Outputs 0x10,0x11,0x12,0x13 on 4 consecutive cycles, first 2 cycles after the handshake.
  - out_last on 0x13; done 1 cycle after.
- Backpressure: cmd_len=6, out_ready toggling 1,0,0,1,...
  - No word lost or duplicated; out_data stable while stalled.
  - sram_enb never issues when buffer+inflight would exceed 2.
  - 6 words total, in order.
- Wrap: cmd_addr=0x1FFE, cmd_len=4.
  - Addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 issued and returned in order.
- Zero length: cmd_len=0.
  - sram_enb stays 0 and out_valid stays 0; done pulses the next cycle; cmd_ready stays 1.
- Reset mid-command: cmd_len=8, assert rst after 3 words delivered with one read in flight.
  - Next cycle out_valid=0, busy=0, cmd_ready=1, no done.
  - A new cmd_len=2 then completes normally.
- With WB_RD_STRIDE_EN: cmd_addr=0x100, cmd_len=3, cmd_stride=0x40.
  - Reads 0x100, 0x140, 0x180.
  - With cmd_stride=0, three reads of 0x100.

Source files
------------

// File: rtl/wb_sram_rd_stream.sv
// Read-side streamer for the weight-buffer SDP SRAM: (addr, len) command in, valid/ready word stream out.
// Optional macro WB_RD_STRIDE_EN adds the cmd_stride port; without it the address increment is 1.
module wb_sram_rd_stream #(
   parameter int AW = 13,
   parameter int DW = 416,
   parameter int LW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
`ifdef WB_RD_STRIDE_EN
   input  logic [AW-1:0] cmd_stride,
`endif
   output logic          sram_enb,
   output logic [AW-1:0] sram_addrb,
   input  logic [DW-1:0] sram_doutb,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done
);
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0] LEN_ONE  = {{(LW-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};

   state_t        state_r, state_nxt_s;
   logic [AW-1:0] cur_addr_r, stride_s;
   logic [LW-1:0] remaining_r;
   logic          inflight_r, inflight_last_r, done_r, valid_r;
   logic [1:0]    count_r, count_nxt_s;
   logic [DW-1:0] head_data_r, head_data_nxt_s, tail_data_r, tail_data_nxt_s;
   logic          head_last_r, head_last_nxt_s, tail_last_r, tail_last_nxt_s;
   logic          hs_s, pop_s, push_s, issue_s, last_pop_s;
   logic [2:0]    credit_s;

`ifdef WB_RD_STRIDE_EN
   logic [AW-1:0] stride_r;
   assign stride_s = stride_r;
`else
   assign stride_s = ADDR_ONE;
`endif

   assign hs_s       = cmd_valid && (state_r == IDLE);
   assign pop_s      = valid_r && out_ready;
   assign push_s     = inflight_r;
   assign last_pop_s = pop_s && head_last_r && (state_r == DRAIN);
   // Slots that will be claimed next cycle; an issue is allowed only if one is still free.
   assign credit_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};

   assign cmd_ready  = (state_r == IDLE);
   assign busy       = (state_r != IDLE);
   assign sram_enb   = issue_s;
   assign sram_addrb = cur_addr_r;
   assign out_valid  = valid_r;
   assign out_data   = head_data_r;
   assign out_last   = head_last_r;
   assign done       = done_r;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and read-issue decision.
   always_comb begin
      state_nxt_s = state_r;
      issue_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (hs_s && (cmd_len != LEN_ZERO)) begin
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if ((remaining_r != LEN_ZERO) && (credit_s <= 3'd1)) begin
               issue_s = 1'b1;
               if (remaining_r == LEN_ONE) begin
                  state_nxt_s = DRAIN;
               end else begin
                  state_nxt_s = ISSUE;
               end
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         DRAIN: begin
            if (last_pop_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Command latch, address walk, in-flight tracking and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr_r      <= {AW{1'b0}};
         remaining_r     <= LEN_ZERO;
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
         done_r          <= 1'b0;
      end else begin
         inflight_r      <= issue_s;
         inflight_last_r <= issue_s && (remaining_r == LEN_ONE);
         done_r          <= (hs_s && (cmd_len == LEN_ZERO)) || last_pop_s;
         if (hs_s) begin
            cur_addr_r  <= cmd_addr;
            remaining_r <= cmd_len;
         end else if (issue_s) begin
            cur_addr_r  <= cur_addr_r + stride_s;
            remaining_r <= remaining_r - LEN_ONE;
         end
      end
   end

`ifdef WB_RD_STRIDE_EN
   // Stride latched with the command.
   always_ff @(posedge clk) begin
      if (rst) begin
         stride_r <= ADDR_ONE;
      end else if (hs_s) begin
         stride_r <= cmd_stride;
      end
   end
`endif

   // Two-entry buffer update; head is what the stream presents.
   always_comb begin
      count_nxt_s     = count_r;
      head_data_nxt_s = head_data_r;
      head_last_nxt_s = head_last_r;
      tail_data_nxt_s = tail_data_r;
      tail_last_nxt_s = tail_last_r;
      case ({push_s, pop_s})
         2'b10: begin
            count_nxt_s = count_r + 2'd1;
            if (count_r == 2'd0) begin
               head_data_nxt_s = sram_doutb;
               head_last_nxt_s = inflight_last_r;
            end else begin
               tail_data_nxt_s = sram_doutb;
               tail_last_nxt_s = inflight_last_r;
            end
         end
         2'b01: begin
            count_nxt_s = count_r - 2'd1;
            if (count_r == 2'd2) begin
               head_data_nxt_s = tail_data_r;
               head_last_nxt_s = tail_last_r;
            end else begin
               head_last_nxt_s = 1'b0;
            end
         end
         2'b11: begin
            if (count_r == 2'd2) begin
               head_data_nxt_s = tail_data_r;
               head_last_nxt_s = tail_last_r;
               tail_data_nxt_s = sram_doutb;
               tail_last_nxt_s = inflight_last_r;
            end else begin
               head_data_nxt_s = sram_doutb;
               head_last_nxt_s = inflight_last_r;
            end
         end
         default: count_nxt_s = count_r;
      endcase
   end

   // Buffer control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r     <= 2'd0;
         valid_r     <= 1'b0;
         head_last_r <= 1'b0;
         tail_last_r <= 1'b0;
      end else begin
         count_r     <= count_nxt_s;
         valid_r     <= (count_nxt_s != 2'd0);
         head_last_r <= head_last_nxt_s;
         tail_last_r <= tail_last_nxt_s;
      end
   end

   // Buffer data registers; contents are meaningless while the entry is empty.
   always_ff @(posedge clk) begin
      head_data_r <= head_data_nxt_s;
      tail_data_r <= tail_data_nxt_s;
   end
endmodule

// File: tb/tb_wb_sram_rd_stream.sv
// Directed self-checking bench for wb_sram_rd_stream with a 1-cycle-latency SRAM model (data[a] = a replicated).
// Stride cases are compiled in only when WB_RD_STRIDE_EN is defined.
module tb_wb_sram_rd_stream;
   localparam int AW = 13;
   localparam int DW = 416;
   localparam int LW = AW + 1;

   logic          clk = 1'b0;
   logic          rst, cmd_valid, cmd_ready, sram_enb, out_valid, out_ready, out_last, busy, done;
   logic [AW-1:0] cmd_addr, sram_addrb;
   logic [LW-1:0] cmd_len;
   logic [DW-1:0] sram_doutb, out_data;
`ifdef WB_RD_STRIDE_EN
   logic [AW-1:0] cmd_stride;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs;

   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return {(DW/AW){a}};
   endfunction

   wb_sram_rd_stream #(.AW(AW), .DW(DW), .LW(LW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
`ifdef WB_RD_STRIDE_EN
      .cmd_stride(cmd_stride),
`endif
      .sram_enb(sram_enb), .sram_addrb(sram_addrb), .sram_doutb(sram_doutb),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (sram_enb) sram_doutb <= word(sram_addrb);

   // Observation log: issues, popped words, done pulses, credit and stall-stability violations.
   logic [AW-1:0] iss_q[$];
   logic [DW-1:0] pop_d[$];
   logic          pop_l[$];
   int            pop_c[$];
   int            done_cnt = 0, done_cyc = -1, credit_err = 0, stall_err = 0, outst = 0;
   logic          prev_stall = 1'b0, prev_last = 1'b0;
   logic [DW-1:0] prev_data;

   always @(negedge clk) begin
      if (rst) begin
         outst      <= 0;
         prev_stall <= 1'b0;
      end else begin
         if (sram_enb) begin
            iss_q.push_back(sram_addrb);
            if (outst - int'(out_valid && out_ready) > 1) credit_err <= credit_err + 1;
         end
         outst <= outst + int'(sram_enb) - int'(out_valid && out_ready);
         if (out_valid && out_ready) begin
            pop_d.push_back(out_data);
            pop_l.push_back(out_last);
            pop_c.push_back(cyc);
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (prev_stall && !(out_valid && out_data === prev_data && out_last === prev_last))
            stall_err <= stall_err + 1;
         prev_stall <= out_valid && !out_ready;
         prev_data  <= out_data;
         prev_last  <= out_last;
      end
   end

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      iss_q.delete();
      pop_d.delete();
      pop_l.delete();
      pop_c.delete();
   endtask

   task automatic send_cmd(input string tag, input logic [AW-1:0] addr, input logic [LW-1:0] len);
      chk_b({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      hs = cyc;
   endtask

   // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
   task automatic wait_done(input string tag, input int mode);
      int   base = done_cnt;
      logic got  = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
         step();
         if (done_cnt != base) got = 1'b1;
      end
      out_ready = 1'b1;
      chk_b({tag, "_done_seen"}, got, 1'b1);
      step();
      step();
      chk_i({tag, "_done_once"}, done_cnt - base, 1);
      chk_b({tag, "_idle_ready"}, cmd_ready, 1'b1);
      chk_b({tag, "_idle_busy"}, busy, 1'b0);
   endtask

   task automatic check_stream(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                               input int n);
      logic [AW-1:0] ea;
      chk_i({tag, "_issue_count"}, iss_q.size(), n);
      chk_i({tag, "_word_count"}, pop_d.size(), n);
      for (int i = 0; i < n; i++) begin
         ea = base + stride * AW'(i);
         if (i < iss_q.size()) chk_i($sformatf("%s_issue_addr%0d", tag, i), int'(iss_q[i]), int'(ea));
         if (i < pop_d.size()) begin
            chk_w($sformatf("%s_data%0d", tag, i), pop_d[i], word(ea));
            chk_b($sformatf("%s_last%0d", tag, i), pop_l[i], (i == n - 1));
         end
      end
      chk_i({tag, "_credit_violations"}, credit_err, 0);
      chk_i({tag, "_stall_violations"}, stall_err, 0);
   endtask

   initial begin
      int d0;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = {AW{1'b0}};
      cmd_len   = {LW{1'b0}};
      out_ready = 1'b1;
`ifdef WB_RD_STRIDE_EN
      cmd_stride = 13'h0001;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk_b("rst_cmd_ready", cmd_ready, 1'b1);
      chk_b("rst_sram_enb", sram_enb, 1'b0);
      chk_b("rst_out_valid", out_valid, 1'b0);
      chk_b("rst_out_last", out_last, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_done", done, 1'b0);

      // Contiguous read at full rate.
      clear_log();
      send_cmd("contig", 13'h0010, 14'd4);
      chk_b("contig_busy", busy, 1'b1);
      chk_b("contig_cmd_ready_low", cmd_ready, 1'b0);
      wait_done("contig", 0);
      check_stream("contig", 13'h0010, 13'h0001, 4);
      if (pop_c.size() == 4) begin
         chk_i("contig_first_cycle", pop_c[0], hs + 2);
         chk_i("contig_last_cycle", pop_c[3], hs + 5);
      end
      chk_i("contig_done_cycle", done_cyc, hs + 6);

      // Backpressure with out_ready 1,0,0 repeating.
      clear_log();
      send_cmd("bp", 13'h0200, 14'd6);
      wait_done("bp", 1);
      check_stream("bp", 13'h0200, 13'h0001, 6);

      // Address wrap at the top of the SRAM.
      clear_log();
      send_cmd("wrap", 13'h1FFE, 14'd4);
      wait_done("wrap", 0);
      check_stream("wrap", 13'h1FFE, 13'h0001, 4);

      // Zero length: done the very next cycle, no SRAM access.
      clear_log();
      d0 = done_cnt;
      send_cmd("zero", 13'h0055, 14'd0);
      chk_b("zero_done_pulse", done, 1'b1);
      chk_b("zero_cmd_ready", cmd_ready, 1'b1);
      chk_b("zero_busy", busy, 1'b0);
      chk_b("zero_out_valid", out_valid, 1'b0);
      step();
      chk_b("zero_done_clear", done, 1'b0);
      step();
      chk_i("zero_issue_count", iss_q.size(), 0);
      chk_i("zero_word_count", pop_d.size(), 0);
      chk_i("zero_done_once", done_cnt - d0, 1);

      // Reset in the middle of a command, then a clean follow-up command.
      clear_log();
      d0 = done_cnt;
      send_cmd("abort", 13'h0040, 14'd8);
      repeat (5) step();
      chk_i("abort_words_before_rst", pop_d.size(), 3);
      chk_i("abort_issues_before_rst", iss_q.size(), 5);
      rst       = 1'b1;
      out_ready = 1'b0;
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      chk_b("abort_out_valid", out_valid, 1'b0);
      chk_b("abort_busy", busy, 1'b0);
      chk_b("abort_cmd_ready", cmd_ready, 1'b1);
      chk_b("abort_done", done, 1'b0);
      chk_b("abort_out_last", out_last, 1'b0);
      repeat (4) step();
      chk_i("abort_no_done", done_cnt - d0, 0);
      chk_i("abort_no_words", pop_d.size(), 3);
      clear_log();
      send_cmd("after", 13'h0020, 14'd2);
      wait_done("after", 0);
      check_stream("after", 13'h0020, 13'h0001, 2);

`ifdef WB_RD_STRIDE_EN
      // Strided read, then stride 0 re-reading one address.
      clear_log();
      cmd_stride = 13'h0040;
      send_cmd("stride", 13'h0100, 14'd3);
      wait_done("stride", 0);
      check_stream("stride", 13'h0100, 13'h0040, 3);

      clear_log();
      cmd_stride = 13'h0000;
      send_cmd("stride0", 13'h0100, 14'd3);
      wait_done("stride0", 1);
      check_stream("stride0", 13'h0100, 13'h0000, 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
